// File: rtl/reg_dump_reader_pkg.sv
// Shared definitions for the register-dump reader and its neighbours.
// Holds the dump FSM state encoding and the register-file geometry that
// the register file, decode stage and dump engine must agree on.
package reg_dump_reader_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STALL  = 3'd1,
    READ   = 3'd2,
    SEND   = 3'd3,
    FINISH = 3'd4
  } dumpState_t;

endpackage

// File: rtl/dump_out_reg.sv
// Purpose: valid/ready holding register for one dumped word (data, addr, last).
// Latency: word is presented the cycle after load; cleared the cycle after handshake or flush.
// Backpressure: contents hold stable while valid and not ready; flush overrides everything.
// Ports:
//   clk, rst          clock and async active-high reset
//   load              capture loadAddr/loadData/loadLast and raise valid
//   flush             drop the held word without a handshake
//   valid/ready       output handshake
//   addr/data/last    held word
module dump_out_reg #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              flush,
  input  logic [ADDR_W-1:0] loadAddr,
  input  logic [DATA_W-1:0] loadData,
  input  logic              loadLast,
  output logic              valid,
  input  logic              ready,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              last
);

  // addr/data keep their last value after a handshake; only valid and last
  // are cleared, so last is never seen high without valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      last  <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      last  <= loadLast;
      addr  <= loadAddr;
      data  <= loadData;
    end else if (valid && ready) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end
  end

endmodule

// File: rtl/reg_dump_reader.sv
// Purpose: debug engine that stalls the core and streams every register-file word out with its index and a running checksum.
// Latency: word k appears 3+2k cycles after start is sampled; done pulses the cycle after the last word is accepted.
// Backpressure: each cycle without dumpReady in SEND holds the word and delays the walk by one cycle.
// Ports:
//   clk, rst                      clock and async active-high reset
//   start, abort                  begin a dump (IDLE only) / cancel a dump
//   busy, stallReq, done          status: engine active, freeze core, completion pulse
//   rdAddr, rdData                combinational register-file read port
//   dumpValid, dumpReady          output word handshake
//   dumpAddr, dumpData, dumpLast  output word contents
//   checksum                      wrapping sum of accepted words
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int DATA_W   = XLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              stallReq,
  output logic              done,
  output logic [ADDR_W-1:0] rdAddr,
  input  logic [DATA_W-1:0] rdData,
  output logic              dumpValid,
  input  logic              dumpReady,
  output logic [ADDR_W-1:0] dumpAddr,
  output logic [DATA_W-1:0] dumpData,
  output logic              dumpLast,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  dumpState_t        state;
  dumpState_t        nextState;
  logic [ADDR_W-1:0] idx;
  logic              idxIsLast;
  logic              handshake;
  logic              acceptWord;
  logic              loadWord;
  logic              flushWord;

  assign idxIsLast = (idx == LAST_IDX);
  assign handshake = dumpValid & dumpReady;
  // abort beats a same-cycle handshake: that word is neither counted nor advanced past
  assign acceptWord = (state == SEND) & handshake & ~abort;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = STALL;
      STALL:   nextState = READ;
      READ:    nextState = SEND;
      SEND:    if (handshake) nextState = idxIsLast ? FINISH : READ;
      FINISH:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (abort && (state != IDLE)) begin
      nextState = IDLE;
    end
  end

  // Output logic
  always_comb begin
    busy      = (state != IDLE);
    stallReq  = (state == STALL) || (state == READ) || (state == SEND);
    done      = (state == FINISH);
    rdAddr    = (state == IDLE) ? '0 : idx;
    loadWord  = (state == READ) && !abort;
    flushWord = abort && (state != IDLE);
  end

  // Index counter and checksum. idx parks on the last index rather than
  // wrapping; checksum holds after done or abort until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      checksum <= '0;
    end else if ((state == IDLE) && start) begin
      idx      <= '0;
      checksum <= '0;
    end else if (acceptWord) begin
      checksum <= checksum + dumpData;
      if (!idxIsLast) begin
        idx <= idx + 1'b1;
      end
    end
  end

  dump_out_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) uOut (
    .clk      (clk),
    .rst      (rst),
    .load     (loadWord),
    .flush    (flushWord),
    .loadAddr (idx),
    .loadData (rdData),
    .loadLast (idxIsLast),
    .valid    (dumpValid),
    .ready    (dumpReady),
    .addr     (dumpAddr),
    .data     (dumpData),
    .last     (dumpLast)
  );

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: register-file array drives the read port, a
// transaction-level model predicts stream contents, timing and checksum.
module tb_reg_dump_reader;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        busy;
  logic        stallReq;
  logic        done;
  logic [4:0]  rdAddr;
  logic [31:0] rdData;
  logic        dumpValid;
  logic        dumpReady;
  logic [4:0]  dumpAddr;
  logic [31:0] dumpData;
  logic        dumpLast;
  logic [31:0] checksum;

  logic [31:0] rf [N];
  assign rdData = rf[rdAddr];

  always #5 clk = ~clk;

  reg_dump_reader #(.NUM_REGS(N), .ADDR_W(5), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .stallReq  (stallReq),
    .done      (done),
    .rdAddr    (rdAddr),
    .rdData    (rdData),
    .dumpValid (dumpValid),
    .dumpReady (dumpReady),
    .dumpAddr  (dumpAddr),
    .dumpData  (dumpData),
    .dumpLast  (dumpLast),
    .checksum  (checksum)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          cyc = 0;
  bit          mBusy;
  bit          mWaiting;     // a word is due or being offered
  int          mIdx;
  int          mValidAt;     // cycle the pending word must appear
  int          mDoneAt;
  logic [31:0] mSum;
  int          startCyc;
  int          firstValid [N];
  int          doneCyc;
  int          wordsSeen;
  int          doneSeen;
  bit          prevValid, prevReady, prevAbort;
  logic [4:0]  prevAddr;
  logic [31:0] prevData;
  bit          readyRandom = 1'b0;

  always @(negedge clk) begin
    bit expValid;
    cyc++;
    if (rst) begin
      mBusy = 0; mWaiting = 0; mIdx = 0; mDoneAt = -1; mSum = 0; prevValid = 0;
      check("rstBusy", 32'(busy), 0);
      check("rstValid", 32'(dumpValid), 0);
      check("rstChecksum", checksum, 0);
    end else begin
      expValid = mWaiting && (cyc >= mValidAt);
      check("busy", 32'(busy), 32'(mBusy));
      check("stallReq", 32'(stallReq), 32'(mBusy && cyc != mDoneAt));
      check("done", 32'(done), 32'(cyc == mDoneAt));
      check("dumpValid", 32'(dumpValid), 32'(expValid));
      check("checksum", checksum, mSum);
      if (expValid) begin
        check("dumpAddr", 32'(dumpAddr), 32'(mIdx));
        check("dumpData", dumpData, rf[mIdx]);
        check("dumpLast", 32'(dumpLast), 32'(mIdx == N - 1));
      end else begin
        check("lastNoValid", 32'(dumpLast), 0);
      end
      if (!mBusy) check("rdAddrIdle", 32'(rdAddr), 0);
      if (prevValid && !prevReady && !prevAbort) begin
        check("holdValid", 32'(dumpValid), 1);
        check("holdAddr", 32'(dumpAddr), 32'(prevAddr));
        check("holdData", dumpData, prevData);
      end
      // observed-event bookkeeping
      if (dumpValid && !prevValid) firstValid[dumpAddr] = cyc;
      if (dumpValid && dumpReady && !abort) wordsSeen++;
      if (done) begin doneSeen++; doneCyc = cyc; end
      // model transitions for the next cycle
      if (mBusy) begin
        if (abort) begin
          mBusy = 0; mWaiting = 0; mDoneAt = -1;
        end else if (cyc == mDoneAt) begin
          mBusy = 0;
        end else if (expValid && dumpReady) begin
          mSum = mSum + rf[mIdx];
          if (mIdx == N - 1) begin
            mWaiting = 0; mDoneAt = cyc + 1;
          end else begin
            mIdx++; mValidAt = cyc + 2;
          end
        end
      end else if (start) begin
        mBusy = 1; mWaiting = 1; mIdx = 0; mSum = 0; mValidAt = cyc + 3;
        mDoneAt = -1; startCyc = cyc;
      end
      prevValid = dumpValid; prevReady = dumpReady; prevAbort = abort;
      prevAddr = dumpAddr; prevData = dumpData;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    dumpReady = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      dumpReady = readyRandom ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic pulseStart();
    wordsSeen = 0; doneSeen = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (doneSeen == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (doneSeen == 0) check("doneTimeout", 32'(doneSeen), 1);
    repeat (3) @(posedge clk);
  endtask

  task automatic waitWord(input int addr, input int budget, output bit found);
    found = 0;
    for (int n = 0; n < budget && !found; n++) begin
      @(posedge clk); #1;
      if (dumpValid && dumpAddr == 5'(addr)) found = 1;
    end
    if (!found) check("wordTimeout", 32'(found), 1);
  endtask

  logic [31:0] expSum;
  bit          found;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    for (int i = 0; i < N; i++) rf[i] = 32'(i * 3);
    rf[2] = 32'd1023;

    // reset values while reset is held, before any clock edge
    #3;
    check("initBusy", 32'(busy), 0);
    check("initStall", 32'(stallReq), 0);
    check("initDone", 32'(done), 0);
    check("initValid", 32'(dumpValid), 0);
    check("initData", dumpData, 0);
    check("initChecksum", checksum, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // full dump, always ready
    readyRandom = 0;
    pulseStart();
    waitDone(200);
    check("fullWords", 32'(wordsSeen), 32);
    check("fullDoneCount", 32'(doneSeen), 1);
    check("fullChecksum", checksum, 32'd2505);
    check("word0At", 32'(firstValid[0] - startCyc), 3);
    check("word31At", 32'(firstValid[31] - startCyc), 65);
    check("doneAfterLast", 32'(doneCyc - firstValid[31]), 1);

    // random backpressure
    readyRandom = 1;
    pulseStart();
    waitDone(600);
    check("bpWords", 32'(wordsSeen), 32);
    check("bpChecksum", checksum, 32'd2505);

    // start re-pulsed mid-dump and in the done cycle
    readyRandom = 0;
    wordsSeen = 0; doneSeen = 0;
    @(posedge clk); #1 start = 1'b1;
    for (int k = 1; k < 200; k++) begin
      @(posedge clk); #1;
      start = (k == 10 || k == 30 || done);
      if (doneSeen != 0 && !done) break;
    end
    start = 1'b0;
    repeat (5) @(posedge clk);
    check("repulseWords", 32'(wordsSeen), 32);
    check("repulseDone", 32'(doneSeen), 1);
    #1 check("repulseIdle", 32'(busy), 0);

    // abort while word 5 is offered with ready high
    pulseStart();
    waitWord(5, 100, found);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("abortBusy", 32'(busy), 0);
    check("abortValid", 32'(dumpValid), 0);
    check("abortStall", 32'(stallReq), 0);
    check("abortChecksum", checksum, 32'd1047);
    repeat (5) @(posedge clk);
    check("abortWords", 32'(wordsSeen), 5);
    check("abortNoDone", 32'(doneSeen), 0);
    pulseStart();
    waitDone(200);
    check("afterAbortWords", 32'(wordsSeen), 32);
    check("afterAbortSum", checksum, 32'd2505);

    // async reset while word 12 is offered
    readyRandom = 1;
    pulseStart();
    waitWord(12, 400, found);
    #1 rst = 1'b1;
    #1;
    check("midRstBusy", 32'(busy), 0);
    check("midRstStall", 32'(stallReq), 0);
    check("midRstValid", 32'(dumpValid), 0);
    check("midRstLast", 32'(dumpLast), 0);
    check("midRstAddr", 32'(dumpAddr), 0);
    check("midRstData", dumpData, 0);
    check("midRstSum", checksum, 0);
    @(posedge clk); #2 rst = 1'b0;

    // fresh random register contents, random backpressure
    expSum = 0;
    for (int i = 0; i < N; i++) begin
      rf[i] = (i == 0) ? 32'd0 : $urandom;
      expSum = expSum + rf[i];
    end
    pulseStart();
    waitDone(600);
    check("rndWords", 32'(wordsSeen), 32);
    check("rndDone", 32'(doneSeen), 1);
    check("rndChecksum", checksum, expSum);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
